// File: rtl/counter_ranged_if.sv
// rtl/counter_ranged_if.sv - control and count bundle for counter_ranged
interface counter_ranged_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  en;
   logic                  dir;
   logic                  clr;
   logic                  load;
   logic [DATA_WIDTH-1:0] load_val;
   logic [DATA_WIDTH-1:0] out;
   logic                  tc;
   logic                  wrap;
   logic                  done;

   modport master (
      output en, dir, clr, load, load_val,
      input  out, tc, wrap, done
   );

   modport slave (
      input  en, dir, clr, load, load_val,
      output out, tc, wrap, done
   );
endinterface

// File: rtl/counter_ranged.sv
// rtl/counter_ranged.sv - up/down counter over an inclusive range with wrap, saturate or one-shot ends
module counter_ranged #(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] COUNT_FROM = '0,
   parameter logic [DATA_WIDTH-1:0] COUNT_TO   = {DATA_WIDTH{1'b1}},
   parameter logic [DATA_WIDTH:0]   STEP       = {{DATA_WIDTH{1'b0}}, 1'b1},
   parameter string                 MODE       = "WRAP"
) (
   input  logic             clk,
   input  logic             rst,
   counter_ranged_if.slave  bus
);

   typedef enum logic [1:0] {
      M_WRAP,
      M_SAT,
      M_ONE
   } mode_e;

   localparam mode_e MODE_SEL = (MODE == "SATURATE") ? M_SAT :
                                (MODE == "ONESHOT")  ? M_ONE : M_WRAP;

   localparam logic [DATA_WIDTH:0] FROM_W = {1'b0, COUNT_FROM};
   localparam logic [DATA_WIDTH:0] TO_W   = {1'b0, COUNT_TO};
   localparam logic [DATA_WIDTH:0] SPAN   = TO_W - FROM_W + 1'b1;

   if (DATA_WIDTH < 2 || DATA_WIDTH > 32) begin : g_bad_width
      $error("counter_ranged: DATA_WIDTH must be 2..32");
   end
   if (COUNT_FROM > COUNT_TO) begin : g_bad_range
      $error("counter_ranged: COUNT_FROM must not exceed COUNT_TO");
   end
   if (STEP == '0 || STEP > SPAN) begin : g_bad_step
      $error("counter_ranged: STEP must be 1..(COUNT_TO-COUNT_FROM+1)");
   end
   if (!(MODE == "WRAP" || MODE == "SATURATE" || MODE == "ONESHOT")) begin : g_bad_mode
      $error("counter_ranged: MODE must be WRAP, SATURATE or ONESHOT");
   end

   logic [DATA_WIDTH-1:0] out_q, out_d;
   logic                  wrap_q, wrap_d;
   logic                  done_q, done_d;

   // Range tests are done one bit wider so out+STEP can never alias back into range.
   logic [DATA_WIDTH:0]   out_w;
   logic [DATA_WIDTH:0]   up_nxt;
   logic                  up_over;
   logic                  dn_under;
   logic [DATA_WIDTH-1:0] dn_nxt;
   logic [DATA_WIDTH:0]   lv_w;
   logic                  lv_below;
   logic                  lv_above;
   logic [DATA_WIDTH:0]   lv_diff_unused;
   logic [DATA_WIDTH-1:0] lv_clamped;

   always_comb begin
      out_w    = {1'b0, out_q};
      up_nxt   = out_w + STEP;
      up_over  = up_nxt > TO_W;
      dn_under = out_w < (FROM_W + STEP);
      dn_nxt   = out_q - STEP[DATA_WIDTH-1:0];
   end

   // Lower clamp uses the borrow of a subtraction so a zero COUNT_FROM is still a live compare.
   always_comb begin
      lv_w                       = {1'b0, bus.load_val};
      {lv_below, lv_diff_unused} = {1'b0, lv_w} - {1'b0, FROM_W};
      lv_above                   = lv_w > TO_W;
      if (lv_below) begin
         lv_clamped = COUNT_FROM;
      end else if (lv_above) begin
         lv_clamped = COUNT_TO;
      end else begin
         lv_clamped = bus.load_val;
      end
   end

   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      done_d = done_q;
      if (bus.clr) begin
         out_d  = bus.dir ? COUNT_TO : COUNT_FROM;
         done_d = 1'b0;
      end else if (bus.load) begin
         out_d  = lv_clamped;
         done_d = 1'b0;
      end else if (bus.en && !done_q) begin
         if (!bus.dir) begin
            if (!up_over) begin
               out_d = up_nxt[DATA_WIDTH-1:0];
            end else begin
               unique case (MODE_SEL)
                  M_WRAP: begin
                     out_d  = COUNT_FROM;
                     wrap_d = 1'b1;
                  end
                  M_SAT: begin
                     out_d  = COUNT_TO;
                     wrap_d = (out_q != COUNT_TO);
                  end
                  default: begin
                     done_d = 1'b1;
                     wrap_d = 1'b1;
                  end
               endcase
            end
         end else begin
            if (!dn_under) begin
               out_d = dn_nxt;
            end else begin
               unique case (MODE_SEL)
                  M_WRAP: begin
                     out_d  = COUNT_TO;
                     wrap_d = 1'b1;
                  end
                  M_SAT: begin
                     out_d  = COUNT_FROM;
                     wrap_d = (out_q != COUNT_FROM);
                  end
                  default: begin
                     done_d = 1'b1;
                     wrap_d = 1'b1;
                  end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_q  <= COUNT_FROM;
         wrap_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
         done_q <= done_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.wrap = wrap_q;
   assign bus.done = done_q;
   assign bus.tc   = bus.dir ? dn_under : up_over;

endmodule

// File: tb/tb_counter_ranged.sv
// tb/tb_counter_ranged.sv - scoreboard bench for counter_ranged in wrap, saturate and one-shot configurations
module tb_counter_ranged;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   counter_ranged_if #(.DATA_WIDTH(8)) ifa ();
   counter_ranged_if #(.DATA_WIDTH(8)) ifb ();
   counter_ranged_if #(.DATA_WIDTH(4)) ifc ();

   counter_ranged #(
      .DATA_WIDTH(8), .COUNT_FROM(8'd20), .COUNT_TO(8'd200), .STEP(9'd10), .MODE("WRAP")
   ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

   counter_ranged #(
      .DATA_WIDTH(8), .COUNT_FROM(8'd20), .COUNT_TO(8'd200), .STEP(9'd7), .MODE("SATURATE")
   ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   counter_ranged #(
      .DATA_WIDTH(4), .COUNT_FROM(4'd0), .COUNT_TO(4'd15), .STEP(5'd4), .MODE("ONESHOT")
   ) dut_c (.clk(clk), .rst(rst), .bus(ifc));

   typedef struct packed {
      logic [7:0] out;
      logic       tc;
      logic       wrap;
      logic       done;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   int checks = 0;
   int passes = 0;

   function automatic logic tc_a(input logic [7:0] o, input logic d);
      return d ? (o < 30) : (int'(o) + 10 > 200);
   endfunction

   function automatic logic tc_b(input logic [7:0] o, input logic d);
      return d ? (o < 27) : (int'(o) + 7 > 200);
   endfunction

   function automatic logic tc_c(input logic [7:0] o, input logic d);
      return d ? (o < 4) : (int'(o) + 4 > 15);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic check_exp(input string name, input exp_t act, input exp_t exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got out=%0d tc=%b wrap=%b done=%b, expected out=%0d tc=%b wrap=%b done=%b",
                    name, act.out, act.tc, act.wrap, act.done, exp.out, exp.tc, exp.wrap, exp.done);
   endtask

   // Every edge with a queued expectation is compared just after it settles.
   always @(posedge clk) begin
      #1;
      if (q_a.size() > 0) begin
         exp_t e;
         exp_t a;
         e = q_a.pop_front();
         a = '{out: ifa.out, tc: ifa.tc, wrap: ifa.wrap, done: ifa.done};
         check_exp("dut_a edge", a, e);
      end
      if (q_b.size() > 0) begin
         exp_t e;
         exp_t a;
         e = q_b.pop_front();
         a = '{out: ifb.out, tc: ifb.tc, wrap: ifb.wrap, done: ifb.done};
         check_exp("dut_b edge", a, e);
      end
      if (q_c.size() > 0) begin
         exp_t e;
         exp_t a;
         e = q_c.pop_front();
         a = '{out: {4'd0, ifc.out}, tc: ifc.tc, wrap: ifc.wrap, done: ifc.done};
         check_exp("dut_c edge", a, e);
      end
   end

   task automatic step_a(input logic en, dir, clr, load, input logic [7:0] lv,
                         input logic [7:0] eo, input logic ew, ed);
      exp_t e;
      @(negedge clk);
      ifa.en = en; ifa.dir = dir; ifa.clr = clr; ifa.load = load; ifa.load_val = lv;
      e = '{out: eo, tc: tc_a(eo, dir), wrap: ew, done: ed};
      q_a.push_back(e);
   endtask

   task automatic step_b(input logic en, dir, clr, load, input logic [7:0] lv,
                         input logic [7:0] eo, input logic ew, ed);
      exp_t e;
      @(negedge clk);
      ifb.en = en; ifb.dir = dir; ifb.clr = clr; ifb.load = load; ifb.load_val = lv;
      e = '{out: eo, tc: tc_b(eo, dir), wrap: ew, done: ed};
      q_b.push_back(e);
   endtask

   task automatic step_c(input logic en, dir, clr, load, input logic [3:0] lv,
                         input logic [7:0] eo, input logic ew, ed);
      exp_t e;
      @(negedge clk);
      ifc.en = en; ifc.dir = dir; ifc.clr = clr; ifc.load = load; ifc.load_val = lv;
      e = '{out: eo, tc: tc_c(eo, dir), wrap: ew, done: ed};
      q_c.push_back(e);
   endtask

   task automatic idle_all();
      @(negedge clk);
      ifa.en = 1'b0; ifa.clr = 1'b0; ifa.load = 1'b0; ifa.dir = 1'b0;
      ifb.en = 1'b0; ifb.clr = 1'b0; ifb.load = 1'b0; ifb.dir = 1'b0;
      ifc.en = 1'b0; ifc.clr = 1'b0; ifc.load = 1'b0; ifc.dir = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0;
      ifa.en = 1'b0; ifa.dir = 1'b0; ifa.clr = 1'b0; ifa.load = 1'b0; ifa.load_val = '0;
      ifb.en = 1'b0; ifb.dir = 1'b0; ifb.clr = 1'b0; ifb.load = 1'b0; ifb.load_val = '0;
      ifc.en = 1'b0; ifc.dir = 1'b0; ifc.clr = 1'b0; ifc.load = 1'b0; ifc.load_val = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("reset a out", 32'(ifa.out), 32'd20);
      check("reset a wrap", 32'(ifa.wrap), 32'd0);
      check("reset a done", 32'(ifa.done), 32'd0);
      check("reset a tc", 32'(ifa.tc), 32'd0);
      check("reset b out", 32'(ifb.out), 32'd20);
      check("reset c out", 32'(ifc.out), 32'd0);

      // WRAP up: 20,30,...,200 then back to 20 with a single wrap pulse
      for (int k = 1; k <= 18; k++) step_a(1, 0, 0, 0, 8'd0, 8'(20 + 10 * k), 0, 0);
      step_a(1, 0, 0, 0, 8'd0, 8'd20, 1, 0);
      step_a(1, 0, 0, 0, 8'd0, 8'd30, 0, 0);
      step_a(0, 0, 0, 0, 8'd0, 8'd30, 0, 0);
      step_a(0, 0, 1, 0, 8'd0, 8'd20, 0, 0);
      step_a(1, 1, 0, 0, 8'd0, 8'd200, 1, 0);
      step_a(1, 1, 0, 0, 8'd0, 8'd190, 0, 0);
      step_a(0, 1, 1, 0, 8'd0, 8'd200, 0, 0);
      step_a(0, 0, 0, 1, 8'd5, 8'd20, 0, 0);
      step_a(0, 0, 0, 1, 8'd250, 8'd200, 0, 0);
      step_a(0, 0, 1, 1, 8'd100, 8'd20, 0, 0);
      step_a(1, 0, 0, 1, 8'd77, 8'd77, 0, 0);
      idle_all();

      // SATURATE up with a non-dividing step, then down from 25
      for (int k = 1; k <= 25; k++) step_b(1, 0, 0, 0, 8'd0, 8'(20 + 7 * k), 0, 0);
      step_b(1, 0, 0, 0, 8'd0, 8'd200, 1, 0);
      step_b(1, 0, 0, 0, 8'd0, 8'd200, 0, 0);
      step_b(1, 0, 0, 0, 8'd0, 8'd200, 0, 0);
      step_b(0, 0, 0, 1, 8'd25, 8'd25, 0, 0);
      step_b(1, 1, 0, 0, 8'd0, 8'd20, 1, 0);
      step_b(1, 1, 0, 0, 8'd0, 8'd20, 0, 0);
      idle_all();

      // ONESHOT: stop at 12, sticky done, clr re-arms
      step_c(1, 0, 0, 0, 4'd0, 8'd4, 0, 0);
      step_c(1, 0, 0, 0, 4'd0, 8'd8, 0, 0);
      step_c(1, 0, 0, 0, 4'd0, 8'd12, 0, 0);
      step_c(1, 0, 0, 0, 4'd0, 8'd12, 1, 1);
      step_c(1, 0, 0, 0, 4'd0, 8'd12, 0, 1);
      step_c(0, 0, 1, 0, 4'd0, 8'd0, 0, 0);
      step_c(1, 0, 0, 0, 4'd0, 8'd4, 0, 0);
      step_c(1, 0, 0, 0, 4'd0, 8'd8, 0, 0);
      step_c(1, 0, 0, 0, 4'd0, 8'd12, 0, 0);
      step_c(1, 0, 0, 0, 4'd0, 8'd12, 1, 1);
      idle_all();

      // Asynchronous reset mid-cycle at out=130, with dut_c holding done=1
      step_a(0, 0, 0, 1, 8'd120, 8'd120, 0, 0);
      step_a(1, 0, 0, 0, 8'd0, 8'd130, 0, 0);
      idle_all();
      @(posedge clk);
      #3;
      check("pre-reset a out", 32'(ifa.out), 32'd130);
      check("pre-reset c done", 32'(ifc.done), 32'd1);
      rst = 1'b0;
      #1;
      check("async reset a out", 32'(ifa.out), 32'd20);
      check("async reset a wrap", 32'(ifa.wrap), 32'd0);
      check("async reset a done", 32'(ifa.done), 32'd0);
      check("async reset c out", 32'(ifc.out), 32'd0);
      check("async reset c done", 32'(ifc.done), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      step_a(1, 0, 0, 0, 8'd0, 8'd30, 0, 0);
      idle_all();

      repeat (3) @(posedge clk);
      #2;
      check("queue a drained", 32'(q_a.size()), 32'd0);
      check("queue b drained", 32'(q_b.size()), 32'd0);
      check("queue c drained", 32'(q_c.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
